// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Command scheduler in front of the 8-bit LED shift register. Each push
//   button is synchronized and debounced; a debounced press becomes a
//   command. LOAD, LEFT and RIGHT are queued and released one per strobe
//   tick. CLEAR bypasses the queue, flushes it and restarts the strobe.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   btns[3:0]  : raw buttons {CLEAR, RIGHT, LOAD, LEFT}
//   switch[7:0]: load value, captured when a LOAD command is issued
//   sr_mode    : one-hot mode to the datapath, same bit order as btns
//   sr_step    : single-cycle step strobe for the datapath
//   sr_data    : value the datapath loads on a LOAD step
//   fifo_count : number of queued commands
//   overflow   : sticky, a command was dropped on a full queue
module shift_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STROBE_TOP      = 99999999,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  btns,
  input  logic [7:0]                  switch,
  output logic [3:0]                  sr_mode,
  output logic                        sr_step,
  output logic [7:0]                  sr_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  // +2 keeps the widths non-zero and able to hold the terminal value itself
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 2);
  localparam int ST_W  = $clog2(STROBE_TOP + 2);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [DB_W-1:0]  DB_TOP   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [ST_W-1:0]  ST_TOP   = ST_W'(STROBE_TOP);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] CLEARED = 2'd0;
  localparam logic [1:0] LOADED  = 2'd1;
  localparam logic [1:0] SHIFT_L = 2'd2;
  localparam logic [1:0] SHIFT_R = 2'd3;

  localparam logic [1:0] CMD_LEFT  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_RIGHT = 2'd2;

  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      db_level;
  logic [3:0]      db_prev;
  logic [DB_W-1:0] db_cnt [4];

  logic [3:0]      rise;
  logic            cmd_clear;
  logic            push_req;
  logic [1:0]      push_code;

  logic [ST_W-1:0] strobe_cnt;
  logic            tick;

  logic [1:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [1:0]      head;
  logic            full;
  logic            pop;
  logic            push;

  logic [1:0]      state;

  // ---- stage: two-flop synchronizer ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btns;
      sync2 <= sync1;
    end
  end

  // ---- stage: per-button debouncer ----
  // The level only moves after the synchronized bit has disagreed with it
  // for DEBOUNCE_CYCLES+1 consecutive samples; any agreement restarts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_level <= '0;
      db_prev  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      db_prev <= db_level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_TOP) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // ---- stage: command generation (CLEAR > LOAD > LEFT > RIGHT) ----
  assign rise = db_level & ~db_prev;

  always_comb begin
    cmd_clear = rise[3];
    push_req  = 1'b0;
    push_code = CMD_LEFT;
    if (!rise[3]) begin
      if (rise[1]) begin
        push_req  = 1'b1;
        push_code = CMD_LOAD;
      end else if (rise[0]) begin
        push_req  = 1'b1;
        push_code = CMD_LEFT;
      end else if (rise[2]) begin
        push_req  = 1'b1;
        push_code = CMD_RIGHT;
      end
    end
  end

  // ---- stage: strobe counter ----
  assign tick = (strobe_cnt == ST_TOP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_cnt <= '0;
    end else if (cmd_clear || tick) begin
      strobe_cnt <= '0;
    end else begin
      strobe_cnt <= strobe_cnt + ST_W'(1);
    end
  end

  // ---- stage: command queue ----
  // A pop frees a slot in the same cycle, so a full queue still accepts a
  // push on a tick. An empty queue cannot forward a same-cycle push.
  assign head = fifo_mem[rd_ptr];
  assign full = (fifo_count == FULL_CNT);
  assign pop  = tick && !cmd_clear && (fifo_count != '0);
  assign push = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_req && full && !pop) overflow <= 1'b1;
      if (cmd_clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop) begin
          fifo_count <= fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
          fifo_count <= fifo_count - CNT_W'(1);
        end
      end
    end
  end

  // ---- stage: scheduler FSM and registered outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEARED;
      sr_mode <= 4'b1000;
      sr_step <= 1'b0;
      sr_data <= '0;
    end else begin
      sr_step <= 1'b0;
      if (cmd_clear) begin
        state   <= CLEARED;
        sr_mode <= 4'b1000;
        sr_step <= 1'b1;
      end else if (pop) begin
        sr_step <= 1'b1;
        case (head)
          CMD_LEFT: begin
            state   <= SHIFT_L;
            sr_mode <= 4'b0001;
          end
          CMD_LOAD: begin
            state   <= LOADED;
            sr_mode <= 4'b0010;
            sr_data <= switch;
          end
          default: begin
            state   <= SHIFT_R;
            sr_mode <= 4'b0100;
          end
        endcase
      end else if (tick && (state == SHIFT_L || state == SHIFT_R)) begin
        // an idle shift state keeps stepping on every tick
        sr_step <= 1'b1;
      end
    end
  end

endmodule
